// File: rtl/data_types_pkg.sv
// Shared types and constants for the UART transmitter: control word layout,
// transmitter state encoding and data-width constants.
package data_types_pkg;

    localparam int BR_DIV_W    = 16;
    localparam int DATA_W      = 9;
    localparam int DATA_BITS_8 = 8;
    localparam int DATA_BITS_9 = 9;

    typedef struct packed {
        logic                en;
        logic                stop;
        logic                word;
        logic [BR_DIV_W-1:0] br_div;
    } ctrl_reg_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Signal bundle between the UART controller and the transmitter.
// The start/idle pair is a level request plus status, not a valid/ready handshake.
interface uart_tx_if
    import data_types_pkg::*;
(
    input logic clk
);

    logic                rst;
    ctrl_reg_t           control;
    logic [DATA_W-1:0]   data;
    logic                start;
    logic                tx;
    logic                idle;
    tx_state_t           dbg_state;

    modport dut (
        input  clk,
        input  rst,
        input  control,
        input  data,
        input  start,
        output tx,
        output idle,
        output dbg_state
    );

endinterface

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..i_div-1 while running and pulses o_tick on
// the last count. Cleared on frame launch so every frame starts on a full period.
module baud_tick
    import data_types_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_run,
    input  logic [BR_DIV_W-1:0] i_div,
    output logic                o_tick
);

    logic [BR_DIV_W-1:0] r_cnt;

    // i_div is never zero here; the transmitter maps 0 to 1 when latching it.
    assign o_tick = i_run && (r_cnt == (i_div - BR_DIV_W'(1)));

    always_ff @(posedge clk) begin
        if (!rst || i_load || !i_run || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + BR_DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 or 9 LSB-first data bits, 1 or 2 stop bits.
// Frame settings are latched at launch so mid-frame control changes are ignored.
module uart_tx
    import data_types_pkg::*;
(
    uart_tx_if.dut bus
);

    tx_state_t           r_state;
    logic [DATA_W-1:0]   r_data;
    logic                r_word;
    logic                r_stop;
    logic [BR_DIV_W-1:0] r_br_div;
    logic [3:0]          r_idx;
    logic                r_tx;
    logic                r_idle;

    tx_state_t           w_state_next;
    logic [3:0]          w_idx_next;
    logic                w_tx_next;
    logic                w_idle_next;
    logic                w_launch;
    logic                w_tick;
    logic [3:0]          w_last_idx;

    assign w_launch   = (r_state == IDLE) && bus.control.en && bus.start;
    assign w_last_idx = r_word ? 4'(DATA_BITS_9 - 1) : 4'(DATA_BITS_8 - 1);

    baud_tick u_baud_tick (
        .clk    (bus.clk),
        .rst    (bus.rst),
        .i_load (w_launch),
        .i_run  (r_state != IDLE),
        .i_div  (r_br_div),
        .o_tick (w_tick)
    );

    // tx is registered, so each branch computes the line level for the next bit.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_tx_next    = r_tx;
        w_idle_next  = r_idle;
        case (r_state)
            IDLE: begin
                w_tx_next   = 1'b1;
                w_idle_next = 1'b1;
                w_idx_next  = 4'd0;
                if (w_launch) begin
                    w_state_next = START;
                    w_tx_next    = 1'b0;
                    w_idle_next  = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                    w_idx_next   = 4'd0;
                    w_tx_next    = r_data[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_idx == w_last_idx) begin
                        w_state_next = STOP;
                        w_idx_next   = 4'd0;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_idx_next = r_idx + 4'd1;
                        w_tx_next  = r_data[r_idx + 4'd1];
                    end
                end
            end
            STOP: begin
                // r_idx counts stop-bit periods here
                if (w_tick) begin
                    if (r_idx == {3'b000, r_stop}) begin
                        w_state_next = IDLE;
                        w_idx_next   = 4'd0;
                        w_tx_next    = 1'b1;
                        w_idle_next  = 1'b1;
                    end else begin
                        w_idx_next = r_idx + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = 4'd0;
                w_tx_next    = 1'b1;
                w_idle_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge bus.clk) begin
        if (!bus.rst) begin
            r_state  <= IDLE;
            r_idx    <= 4'd0;
            r_tx     <= 1'b1;
            r_idle   <= 1'b1;
            r_data   <= '0;
            r_word   <= 1'b0;
            r_stop   <= 1'b0;
            r_br_div <= BR_DIV_W'(1);
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
            r_idle  <= w_idle_next;
            if (w_launch) begin
                r_data   <= bus.data;
                r_word   <= bus.control.word;
                r_stop   <= bus.control.stop;
                r_br_div <= (bus.control.br_div == '0) ? BR_DIV_W'(1) : bus.control.br_div;
            end
        end
    end

    assign bus.tx        = r_tx;
    assign bus.idle      = r_idle;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frames are checked bit-by-bit against
// hand-computed line sequences, sampled on the falling clock edge.
module tb_uart_tx;
    import data_types_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if u_if (.clk(clk));
    uart_tx    u_dut (.bus(u_if.dut));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctrl(input logic en, input logic stop, input logic word,
                            input logic [15:0] div);
        u_if.control = '{en: en, stop: stop, word: word, br_div: div};
    endtask

    task automatic chk_idle_line(input string tag);
        chk({tag, "_tx"},   {3'b000, u_if.tx},   4'd1);
        chk({tag, "_idle"}, {3'b000, u_if.idle}, 4'd1);
    endtask

    // Call right after the launch edge; seq[0] is the first bit on the line.
    task automatic check_frame(input string tag, input logic [11:0] seq,
                               input int nbits, input int div);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                chk({tag, "_tx"},   {3'b000, u_if.tx},   {3'b000, seq[b]});
                chk({tag, "_busy"}, {3'b000, u_if.idle}, 4'd0);
            end
        end
        @(negedge clk);
        chk_idle_line({tag, "_end"});
    endtask

    initial begin
        u_if.rst   = 1'b0;
        u_if.start = 1'b0;
        u_if.data  = '0;
        set_ctrl(1'b1, 1'b0, 1'b0, 16'd8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_line("reset");
        chk("reset_state", {2'b00, u_if.dbg_state}, {2'b00, IDLE});
        u_if.rst = 1'b1;
        @(negedge clk);
        chk_idle_line("post_reset");

        // 8-bit frame, 0x8E
        u_if.data  = 9'h08E;
        u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        check_frame("f_8e", 12'b001100011100, 10, 8);

        // 0x81; en, settings and data change right after launch must not matter
        u_if.data  = 9'h081;
        u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        set_ctrl(1'b0, 1'b1, 1'b1, 16'd3);
        u_if.data = 9'h1FF;
        check_frame("f_81", 12'b001100000010, 10, 8);

        // disabled: start held high must not launch
        u_if.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk_idle_line("disabled");
        end
        u_if.start = 1'b0;

        // 9-bit frame, 0x1FE
        set_ctrl(1'b1, 1'b0, 1'b1, 16'd8);
        u_if.data  = 9'h1FE;
        u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        check_frame("f_9bit", 12'b011111111100, 11, 8);

        // back-to-back 9-bit frames with 2 stop bits, start held high
        set_ctrl(1'b1, 1'b1, 1'b1, 16'd8);
        u_if.data  = 9'h0A5;
        u_if.start = 1'b1;
        @(posedge clk);
        check_frame("b2b_a", 12'b110101001010, 12, 8);
        @(posedge clk);
        check_frame("b2b_b", 12'b110101001010, 12, 8);
        u_if.start = 1'b0;
        @(negedge clk);
        chk_idle_line("b2b_stop");

        // br_div of zero behaves as one cycle per bit
        set_ctrl(1'b1, 1'b0, 1'b0, 16'd0);
        u_if.data  = 9'h055;
        u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        check_frame("div0", 12'b001010101010, 10, 1);

        // reset asserted for one edge while sending data bit 0 (a zero)
        set_ctrl(1'b1, 1'b0, 1'b0, 16'd8);
        u_if.data  = 9'h08E;
        u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        repeat (11) @(negedge clk);
        chk("pre_rst_state", {2'b00, u_if.dbg_state}, {2'b00, DATA});
        chk("pre_rst_tx", {3'b000, u_if.tx}, 4'd0);
        u_if.rst = 1'b0;
        @(posedge clk);
        #1 u_if.rst = 1'b1;
        @(negedge clk);
        chk_idle_line("mid_rst");
        chk("mid_rst_state", {2'b00, u_if.dbg_state}, {2'b00, IDLE});
        @(negedge clk);
        chk_idle_line("after_rst");

        u_if.data  = 9'h081;
        u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        check_frame("f_after_rst", 12'b001100000010, 10, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Asynchronous serial transmitter that serialises one 8- or 9-bit word per frame onto a single tx line. Frame format is 1 start bit, LSB-first data, and 1 or 2 stop bits, with no parity. Bit period is programmable in clock cycles. It sits behind the UART controller's control register and is driven through the uart_tx_if interface; it reports line-idle status to the host logic.

Parameters:
BR_DIV_W, 16, width of the baud-divider field in the control word
DATA_W, 9, width of the data input (bit 8 used only in 9-bit mode)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets)
control  input  ctrl_reg_t  {en, stop, word, br_div[BR_DIV_W-1:0]}
data  input  DATA_W  word to transmit
start  input  1  level request to begin a frame
tx  output  1  serial line, high when idle
idle  output  1  high when no frame is in progress

Behaviour:
- One clock, one synchronous active-low reset; clock and reset carried in uart_tx_if as clk and rst.
- Reset (rst==0 at an edge): state=IDLE, tx=1, idle=1, counters cleared. Applies mid-frame too: the frame is aborted and the line returns high on that edge.
- Control fields:
  - word: 0 = 8 data bits, 1 = 9 data bits.
  - stop: 0 = 1 stop bit, 1 = 2 stop bits.
  - en: 1 = transmitter enabled.
  - br_div: clock cycles per bit; a value of 0 is treated as 1.
- States are IDLE, START, DATA, STOP.
- IDLE: tx=1, idle=1. If en==1 and start==1 at a rising edge:
  - latch data, word, stop and br_div into internal registers;
  - go to START; tx=0 and idle=0 from that same edge (registered outputs, so visible one cycle after start is sampled).
  - start and data are don't-care after this launch edge.
- START: hold tx=0 for br_div cycles, then go to DATA with bit index 0.
- DATA: drive tx=latched_data[idx] for br_div cycles per bit, LSB first. Advance idx until idx = N-1, with N = 8 or 9; then go to STOP.
- STOP: tx=1 for br_div*S cycles, with S = 1 or 2. At the end, return to IDLE and set idle=1 on the same edge.
- Total frame time is (1+N+S)*br_div cycles from the launch edge to the idle-rise edge.
- start is level-sensitive: if still high when IDLE is re-entered, a new frame launches on the next edge. The line is therefore high for at least 1 cycle between frames.
- Control or data changes during a frame have no effect on that frame; they apply from the next launch.
- en dropping to 0 mid-frame: the current frame completes, and no new frame launches while en==0.
- Bit-period counter counts 0..br_div-1. It is the only counter wider than 4 bits; the bit index is 4 bits.

Decomposition:
- Shared package data_types_pkg holds:
  - typedef ctrl_reg_t, a packed struct {en, stop, word, br_div};
  - the tx state enum;
  - constants DATA_BITS_8=8, DATA_BITS_9=9.
- Interface uart_tx_if(input clk) bundles rst, control, data, start, tx and idle, with a modport for the DUT; uart_tx takes the interface modport.
- Optional single sub-module baud_tick, a bit-period counter producing a one-cycle tick every br_div cycles, reloaded at each frame launch.

Test Plan:
- Basic 8-bit frame: br_div=8, word=0, stop=0, en=1, data=0x8E, pulse start. Required response: tx = 0,0,1,1,1,0,0,0,1,1, each bit held 8 cycles; idle low for exactly 80 cycles.
- Second 8-bit frame: after idle, data=0x81. Required response: tx = 0,1,0,0,0,0,0,0,1,1; idle returns high after 80 cycles.
- 9-bit mode: word=1, data=0x1FE. Required response: tx = 0,0,1,1,1,1,1,1,1,1,1 (11 bits, 88 cycles).
- Two stop bits with back-to-back frames: stop=1, start held high continuously. Required response:
  - with word=1, stop high for 16 cycles per frame;
  - frames repeat, separated by exactly one idle cycle.
- Disable: en=0, start=1. Required response: tx stays 1 and idle stays 1 indefinitely.
- Mid-frame reset: rst=0 for 1 edge during the DATA state. Required response: tx=1 and idle=1 on that edge; after release, a new start gives a full, correct frame.
